// File: rtl/branch_resolver.sv
// branch_resolver
//   Consumer side of the branch predictor interface. Every conditional
//   branch leaving ID is recorded, with its prediction and history snapshot,
//   in an in-order in-flight queue. When the branch reaches WB, the queue
//   head is retired: the predictor update is strobed, and a misprediction
//   triggers a redirect and a multi-cycle flush. Saturating performance
//   counters track resolved branches and mispredicts.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   id_push             branch leaves ID this cycle
//   predict_taken       prediction used in ID
//   branch_hist_id      history snapshot used for that prediction
//   wb_resolve          branch in WB this cycle
//   taken_wb            actual outcome in WB
//   PC_wb, target_wb    branch PC and computed target in WB
//   enable              predictor update strobe (combinational)
//   branch_hist_wb      history of the queue head (combinational)
//   stall_id            queue full, ID must hold
//   flush               squash IF..MEM
//   redirect_valid      one-cycle pulse to load redirect_pc
//   redirect_pc         corrected fetch address
//   underflow           sticky: resolve seen with an empty queue
//   branch_count        resolved branches (saturating)
//   mispredict_count    mispredicts (saturating)
//
// State table
//   state   | meaning
//   S_IDLE  | normal operation: push, resolve, update
//   S_FLUSH | pipeline flush in progress, ID/WB traffic ignored
module branch_resolver #(
  parameter int hist_reg_width = 4,
  parameter int depth          = 4,
  parameter int flush_cycles   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_push,
  input  logic                      predict_taken,
  input  logic [hist_reg_width-1:0] branch_hist_id,
  input  logic                      wb_resolve,
  input  logic                      taken_wb,
  input  logic [15:0]               PC_wb,
  input  logic [15:0]               target_wb,
  output logic                      enable,
  output logic [hist_reg_width-1:0] branch_hist_wb,
  output logic                      stall_id,
  output logic                      flush,
  output logic                      redirect_valid,
  output logic [15:0]               redirect_pc,
  output logic                      underflow,
  output logic [15:0]               branch_count,
  output logic [15:0]               mispredict_count
);

  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(flush_cycles + 1);
  localparam logic [CW-1:0] FLUSH_INIT = CW'(flush_cycles - 1);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             cnt, cnt_nxt;
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic                      pred_mem [depth];
  logic [hist_reg_width-1:0] hist_mem [depth];

  logic idle, full, empty, push, mispredict;

  assign idle  = (state == S_IDLE);
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[PW-1] != rd_ptr[PW-1]);

  assign stall_id       = full;
  assign enable         = wb_resolve & ~empty & idle;
  assign branch_hist_wb = hist_mem[rd_ptr[AW-1:0]];
  assign mispredict     = enable & (pred_mem[rd_ptr[AW-1:0]] != taken_wb);

  // A full queue still accepts a push when the head retires the same cycle.
  assign push = id_push & idle & (~full | enable);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    flush     = 1'b0;
    case (state)
      S_IDLE: begin
        if (mispredict) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = FLUSH_INIT;
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Payload storage needs no reset: it is only visible while the queue is
  // non-empty, and the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pred_mem[wr_ptr[AW-1:0]] <= predict_taken;
      hist_mem[wr_ptr[AW-1:0]] <= branch_hist_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (mispredict) begin
      // Everything younger than the mispredicted branch is wrong-path,
      // including a branch pushed this very cycle.
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (enable) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      underflow        <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict)
        redirect_pc <= taken_wb ? target_wb : PC_wb + 16'd2;
      if (wb_resolve & empty & idle)
        underflow <= 1'b1;
      if (enable && branch_count != 16'hFFFF)
        branch_count <= branch_count + 16'd1;
      if (mispredict && mispredict_count != 16'hFFFF)
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
  localparam int H  = 4;
  localparam int D  = 4;
  localparam int FC = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_push, predict_taken, wb_resolve, taken_wb;
  logic [H-1:0]  branch_hist_id;
  logic [15:0]   PC_wb, target_wb;
  logic          enable, stall_id, flush, redirect_valid, underflow;
  logic [H-1:0]  branch_hist_wb;
  logic [15:0]   redirect_pc, branch_count, mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_resolver #(.hist_reg_width(H), .depth(D), .flush_cycles(FC)) dut (
    .clk(clk), .reset(reset), .id_push(id_push), .predict_taken(predict_taken),
    .branch_hist_id(branch_hist_id), .wb_resolve(wb_resolve), .taken_wb(taken_wb),
    .PC_wb(PC_wb), .target_wb(target_wb), .enable(enable),
    .branch_hist_wb(branch_hist_wb), .stall_id(stall_id), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .underflow(underflow), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of {pred, hist}, flush as cycles remaining.
  logic [H:0] q[$];
  int         m_left;
  bit         m_rv, m_uf;
  logic [15:0] m_rpc;
  int         m_bc, m_mc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_left = 0; m_rv = 0; m_uf = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
    end else begin
      m_rv = 0;
      if (m_left > 0) begin
        m_left = m_left - 1;
      end else if (wb_resolve && q.size() == 0) begin
        m_uf = 1;
        if (id_push) q.push_back({predict_taken, branch_hist_id});
      end else begin
        bit res, mis, was_full;
        logic [H:0] head;
        res = wb_resolve && q.size() > 0;
        was_full = (q.size() == D);
        mis = 0;
        if (res) begin
          head = q.pop_front();
          if (m_bc < 65535) m_bc++;
          mis = (head[H] != taken_wb);
        end
        if (mis) begin
          if (m_mc < 65535) m_mc++;
          m_rv = 1;
          m_rpc = taken_wb ? target_wb : 16'(PC_wb + 16'd2);
          q.delete();
          m_left = FC;
        end else if (id_push && (!was_full || res)) begin
          q.push_back({predict_taken, branch_hist_id});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("enable", {31'b0, enable}, {31'b0, (m_left == 0) && wb_resolve && q.size() > 0});
      if (q.size() > 0) chk("branch_hist_wb", {28'b0, branch_hist_wb}, {28'b0, q[0][H-1:0]});
      chk("stall_id", {31'b0, stall_id}, {31'b0, q.size() == D});
      chk("flush", {31'b0, flush}, {31'b0, m_left > 0});
      chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_rv});
      chk("redirect_pc", {16'b0, redirect_pc}, {16'b0, m_rpc});
      chk("underflow", {31'b0, underflow}, {31'b0, m_uf});
      chk("branch_count", {16'b0, branch_count}, m_bc);
      chk("mispredict_count", {16'b0, mispredict_count}, m_mc);
    end
  end

  // Apply one cycle of inputs; returns 2 time units after the capturing edge.
  task automatic cyc(input bit p, input bit pt, input logic [H-1:0] h,
                     input bit r, input bit t, input logic [15:0] pc,
                     input logic [15:0] tg);
    id_push = p; predict_taken = pt; branch_hist_id = h;
    wb_resolve = r; taken_wb = t; PC_wb = pc; target_wb = tg;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, '0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    reset = 1'b1;
    id_push = 0; predict_taken = 0; branch_hist_id = '0;
    wb_resolve = 0; taken_wb = 0; PC_wb = '0; target_wb = '0;
    @(posedge clk); #2;
    reset = 1'b0;
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_stall", {31'b0, stall_id}, 0);
    chk("rst_redirect_pc", {16'b0, redirect_pc}, 0);
    chk("rst_count", {16'b0, branch_count}, 0);

    // Two correct predictions.
    cyc(1, 1, 4'h3, 0, 0, 16'h0, 16'h0);
    cyc(1, 0, 4'h5, 0, 0, 16'h0, 16'h0);
    chk("head_hist_3", {28'b0, branch_hist_wb}, 32'h3);
    cyc(0, 0, 4'h0, 1, 1, 16'h0010, 16'h0020);
    chk("head_hist_5", {28'b0, branch_hist_wb}, 32'h5);
    cyc(0, 0, 4'h0, 1, 0, 16'h0014, 16'h0030);
    chk("t1_branch_count", {16'b0, branch_count}, 2);
    chk("t1_mispredict_count", {16'b0, mispredict_count}, 0);
    chk("t1_flush", {31'b0, flush}, 0);

    // Mispredict: predicted N, actually taken.
    cyc(1, 0, 4'hA, 0, 0, 16'h0, 16'h0);
    cyc(0, 0, 4'h0, 1, 1, 16'h0040, 16'h0100);
    chk("t2_redirect_valid", {31'b0, redirect_valid}, 1);
    chk("t2_redirect_pc", {16'b0, redirect_pc}, 32'h0100);
    chk("t2_flush_c1", {31'b0, flush}, 1);
    cyc(1, 1, 4'h7, 1, 1, 16'h0050, 16'h0200);
    chk("t2_redirect_pulse", {31'b0, redirect_valid}, 0);
    chk("t2_flush_c2", {31'b0, flush}, 1);
    cyc(1, 1, 4'h7, 1, 1, 16'h0050, 16'h0200);
    chk("t2_flush_c3", {31'b0, flush}, 1);
    cyc(1, 1, 4'h7, 1, 1, 16'h0050, 16'h0200);
    chk("t2_flush_end", {31'b0, flush}, 0);
    chk("t2_mispredict_count", {16'b0, mispredict_count}, 1);
    chk("t2_branch_count", {16'b0, branch_count}, 3);
    chk("t2_underflow", {31'b0, underflow}, 0);

    // Mispredict with PC wraparound.
    cyc(1, 1, 4'h1, 0, 0, 16'h0, 16'h0);
    cyc(0, 0, 4'h0, 1, 0, 16'hFFFE, 16'h1234);
    chk("t3_redirect_pc_wrap", {16'b0, redirect_pc}, 32'h0000);
    chk("t3_mispredict_count", {16'b0, mispredict_count}, 2);
    repeat (FC) idle_cyc();

    // Fill, overflow attempt, push+pop while full, drain.
    for (int i = 1; i <= 4; i++) cyc(1, 1, 4'(i), 0, 0, 16'h0, 16'h0);
    chk("t4_stall_full", {31'b0, stall_id}, 1);
    cyc(1, 1, 4'h9, 0, 0, 16'h0, 16'h0);
    chk("t4_drop_head", {28'b0, branch_hist_wb}, 32'h1);
    cyc(1, 1, 4'h6, 1, 1, 16'h0, 16'h0);
    chk("t4_still_full", {31'b0, stall_id}, 1);
    chk("t4_head_adv", {28'b0, branch_hist_wb}, 32'h2);
    repeat (4) cyc(0, 0, 4'h0, 1, 1, 16'h0, 16'h0);
    chk("t4_drained", {31'b0, stall_id}, 0);
    chk("t4_branch_count", {16'b0, branch_count}, 9);

    // Underflow, then reset in the middle of a flush.
    cyc(0, 0, 4'h0, 1, 1, 16'h0, 16'h0);
    chk("t5_underflow", {31'b0, underflow}, 1);
    chk("t5_bc_unchanged", {16'b0, branch_count}, 9);
    idle_cyc();
    chk("t5_underflow_sticky", {31'b0, underflow}, 1);
    cyc(1, 1, 4'h2, 0, 0, 16'h0, 16'h0);
    cyc(0, 0, 4'h0, 1, 0, 16'h0080, 16'h0090);
    chk("t5_in_flush", {31'b0, flush}, 1);
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_flush", {31'b0, flush}, 0);
    chk("t5_rst_bc", {16'b0, branch_count}, 0);
    chk("t5_rst_mc", {16'b0, mispredict_count}, 0);
    chk("t5_rst_underflow", {31'b0, underflow}, 0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Saturate branch_count.
    cyc(1, 1, 4'h4, 0, 0, 16'h0, 16'h0);
    repeat (65535) cyc(1, 1, 4'h4, 1, 1, 16'h0, 16'h0);
    chk("t6_bc_max", {16'b0, branch_count}, 32'hFFFF);
    cyc(1, 1, 4'h4, 1, 1, 16'h0, 16'h0);
    chk("t6_bc_hold", {16'b0, branch_count}, 32'hFFFF);
    idle_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
